// File: rtl/cmd_serializer.sv
// cmd_serializer: turns a 56-bit command word into a byte stream for a UART
// transmitter, header byte first, with an optional idle gap between bytes.
// Optional feature: define CMD_SERIALIZER_CHECKSUM_EN to append an XOR
// checksum byte to every frame (8 bytes instead of 7).
module cmd_serializer #(
  parameter int IDLE_GAP = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [55:0] cmd_in,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done
);

  // Last value of the gap counter before returning to SEND.
  localparam logic [3:0] GAP_LAST = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;
  localparam bit         HAS_GAP  = (IDLE_GAP > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
`ifdef CMD_SERIALIZER_CHECKSUM_EN
    GAP  = 2'd2,
    CSUM = 2'd3
`else
    GAP  = 2'd2
`endif
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [55:0] shreg;
  logic [2:0]  bytecnt;
  logic [3:0]  gapcnt;
  logic        load;
  logic        advance;
  logic        last_hs;
`ifdef CMD_SERIALIZER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  // State register; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = shreg[55:48];
    load       = 1'b0;
    advance    = 1'b0;
    last_hs    = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          load       = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          advance = 1'b1;
          if (bytecnt == 3'd6) begin
`ifdef CMD_SERIALIZER_CHECKSUM_EN
            if (HAS_GAP) state_next = GAP;
            else         state_next = CSUM;
`else
            last_hs    = 1'b1;
            state_next = IDLE;
`endif
          end else begin
            if (HAS_GAP) state_next = GAP;
            else         state_next = SEND;
          end
        end
      end
      GAP: begin
        if (gapcnt == GAP_LAST) begin
`ifdef CMD_SERIALIZER_CHECKSUM_EN
          if (bytecnt == 3'd7) state_next = CSUM;
          else                 state_next = SEND;
`else
          state_next = SEND;
`endif
        end
      end
`ifdef CMD_SERIALIZER_CHECKSUM_EN
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        if (tx_ready) begin
          last_hs    = 1'b1;
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Shift register, byte/gap counters, checksum and the frame_done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg      <= 56'd0;
      bytecnt    <= 3'd0;
      gapcnt     <= 4'd0;
      frame_done <= 1'b0;
`ifdef CMD_SERIALIZER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      frame_done <= last_hs;
      if (load) begin
        shreg   <= cmd_in;
        bytecnt <= 3'd0;
`ifdef CMD_SERIALIZER_CHECKSUM_EN
        csum    <= 8'd0;
`endif
      end else if (advance) begin
        shreg   <= {shreg[47:0], 8'h00};
        bytecnt <= bytecnt + 3'd1;
`ifdef CMD_SERIALIZER_CHECKSUM_EN
        csum    <= csum ^ shreg[55:48];
`endif
      end
      if (state == GAP) gapcnt <= gapcnt + 4'd1;
      else              gapcnt <= 4'd0;
    end
  end

endmodule
